// File: rtl/pipe_event_counter.sv
// rtl/pipe_event_counter.sv - pipeline performance-event counter with snapshot shadows
//
// Purpose:
//   Counts cycles, stalls, flushes, retired instructions and taken branches
//   while the CPU is in RUN. The counts can be frozen into shadow registers,
//   which are then read one at a time through data_o.
//   Optional feature macro: PERF_WINDOW_EN (periodic snapshot every WINDOW RUN cycles).
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        CPU running; counting enabled only while high
//   halt_i         one-cycle pulse, program finished
//   stall_i        hazard unit bubble this cycle
//   flush_i        IF/ID flush this cycle
//   branch_taken_i branch resolved taken in ID
//   retire_i       instruction committed in WB
//   clear_i        zero live counters and overflow flags
//   snap_req_i     snapshot request (level or pulse)
//   snap_ack_o     one-cycle pulse after a shadow update
//   sel_i          shadow select: 0 cycle, 1 stall, 2 flush, 3 retire, 4 branch, 5-7 zero
//   data_o         selected shadow value, registered
//   ovf_o          sticky saturation flags, bit order as sel_i
//   state_o        FSM state: 0 IDLE, 1 RUN, 2 DONE

module pipe_event_counter #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned WINDOW = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             branch_taken_i,
  input  logic             retire_i,
  input  logic             clear_i,
  input  logic             snap_req_i,
  output logic             snap_ack_o,
  input  logic [2:0]       sel_i,
  output logic [CNT_W-1:0] data_o,
  output logic [4:0]       ovf_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_MAX = '1;
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic             w_run;
  logic [4:0]       w_inc;
  logic [CNT_W-1:0] r_cnt     [5];
  logic [CNT_W-1:0] w_cnt_inc [5];
  logic [CNT_W-1:0] r_shadow  [5];
  logic [4:0]       w_ovf_set;
  logic [4:0]       r_ovf;
  logic             r_snap_ack;
  logic             w_snap_fire;
  logic             w_win_fire;
  logic [CNT_W-1:0] w_sel_val;
  logic [CNT_W-1:0] r_data;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start_i) w_state_next = ST_RUN;
      // halt wins over a simultaneous start drop so the run ends in DONE
      ST_RUN: begin
        if (halt_i) begin
          w_state_next = ST_DONE;
        end else if (!start_i) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_DONE: if (clear_i) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_run = (r_state == ST_RUN);

  // Increment enables, bit order matches sel_i / ovf_o.
  // A flush cycle is never also counted as a stall.
  assign w_inc = w_run ? {branch_taken_i, retire_i, flush_i, stall_i & ~flush_i, 1'b1}
                       : 5'b00000;

  // ---------------------------------------------------------------- counters
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      w_cnt_inc[k] = r_cnt[k];
      if (w_inc[k] && (r_cnt[k] != LP_MAX)) begin
        w_cnt_inc[k] = r_cnt[k] + LP_ONE;
      end
      w_ovf_set[k] = w_inc[k] && (w_cnt_inc[k] == LP_MAX);
    end
  end

  // clear_i discards this cycle's events, so it simply zeroes instead of adding
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int k = 0; k < 5; k++) begin
        r_cnt[k] <= '0;
      end
      r_ovf <= 5'b00000;
    end else begin
      for (int k = 0; k < 5; k++) begin
        r_cnt[k] <= w_cnt_inc[k];
      end
      r_ovf <= r_ovf | w_ovf_set;
    end
  end

  // ---------------------------------------------------------------- window
`ifdef PERF_WINDOW_EN
  localparam int unsigned        LP_WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [LP_WIN_W-1:0] LP_WIN_LAST = LP_WIN_W'(WINDOW - 1);
  localparam logic [LP_WIN_W-1:0] LP_WIN_ONE  = LP_WIN_W'(1);

  logic [LP_WIN_W-1:0] r_win;

  assign w_win_fire = w_run && (r_win == LP_WIN_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || !w_run || w_win_fire) begin
      r_win <= '0;
    end else begin
      r_win <= r_win + LP_WIN_ONE;
    end
  end
`else
  // WINDOW only matters when the periodic snapshot is built in
  logic [31:0] w_unused_window;
  assign w_unused_window = WINDOW;
  assign w_win_fire      = 1'b0;
`endif

  // ---------------------------------------------------------------- snapshot
  // A user request in the ack cycle is dropped (busy); a window snapshot
  // merges with a coincident user request into a single capture.
  assign w_snap_fire = w_win_fire | (snap_req_i & ~r_snap_ack);

  // Shadows take the post-increment, pre-clear values of this edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 5; k++) begin
        r_shadow[k] <= '0;
      end
      r_snap_ack <= 1'b0;
    end else begin
      r_snap_ack <= w_snap_fire;
      if (w_snap_fire) begin
        for (int k = 0; k < 5; k++) begin
          r_shadow[k] <= w_cnt_inc[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------- read port
  always_comb begin
    w_sel_val = '0;
    case (sel_i)
      3'd0:    w_sel_val = r_shadow[0];
      3'd1:    w_sel_val = r_shadow[1];
      3'd2:    w_sel_val = r_shadow[2];
      3'd3:    w_sel_val = r_shadow[3];
      3'd4:    w_sel_val = r_shadow[4];
      default: w_sel_val = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data <= '0;
    end else begin
      r_data <= w_sel_val;
    end
  end

  assign snap_ack_o = r_snap_ack;
  assign data_o     = r_data;
  assign ovf_o      = r_ovf;
  assign state_o    = r_state;

endmodule

// File: tb/tb_pipe_event_counter.sv
// tb/tb_pipe_event_counter.sv - directed bench for pipe_event_counter
module tb_pipe_event_counter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        halt_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic        retire_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        snap_req_i = 1'b0;
  logic [2:0]  sel_i = 3'd0;

  logic        ack_m, ack_s, ack_w;
  logic [31:0] data_m, data_w;
  logic [3:0]  data_s;
  logic [4:0]  ovf_m, ovf_s, ovf_w;
  logic [1:0]  st_m, st_s, st_w;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_event_counter #(.CNT_W(32), .WINDOW(1024)) u_main (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
    .stall_i(stall_i), .flush_i(flush_i), .branch_taken_i(branch_taken_i),
    .retire_i(retire_i), .clear_i(clear_i), .snap_req_i(snap_req_i),
    .snap_ack_o(ack_m), .sel_i(sel_i), .data_o(data_m), .ovf_o(ovf_m), .state_o(st_m)
  );

  pipe_event_counter #(.CNT_W(4), .WINDOW(1024)) u_small (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
    .stall_i(stall_i), .flush_i(flush_i), .branch_taken_i(branch_taken_i),
    .retire_i(retire_i), .clear_i(clear_i), .snap_req_i(snap_req_i),
    .snap_ack_o(ack_s), .sel_i(sel_i), .data_o(data_s), .ovf_o(ovf_s), .state_o(st_s)
  );

  pipe_event_counter #(.CNT_W(32), .WINDOW(8)) u_win (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
    .stall_i(stall_i), .flush_i(flush_i), .branch_taken_i(branch_taken_i),
    .retire_i(retire_i), .clear_i(clear_i), .snap_req_i(snap_req_i),
    .snap_ack_o(ack_w), .sel_i(sel_i), .data_o(data_w), .ovf_o(ovf_w), .state_o(st_w)
  );

  typedef struct {
    int   n;
    logic stall;
    logic flush;
    logic retire;
    logic branch;
    logic halt;
    logic snap;
  } phase_t;

  typedef struct {
    int          tid;
    logic [2:0]  sel;
    logic [31:0] exp;
  } rd_t;

  phase_t ph2 [5];
  phase_t ph3 [5];
  rd_t    rd  [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_phase(input phase_t p);
    stall_i        = p.stall;
    flush_i        = p.flush;
    retire_i       = p.retire;
    branch_taken_i = p.branch;
    halt_i         = p.halt;
    snap_req_i     = p.snap;
    for (int c = 0; c < p.n; c++) step();
    stall_i = 0; flush_i = 0; retire_i = 0; branch_taken_i = 0; halt_i = 0; snap_req_i = 0;
  endtask

  task automatic do_reads(input int tid);
    for (int i = 0; i < 16; i++) begin
      if (rd[i].tid == tid) begin
        sel_i = rd[i].sel;
        step();
        chk($sformatf("t%0d_sel%0d", tid, rd[i].sel), data_m, rd[i].exp);
      end
    end
  endtask

  initial begin
    // n, stall, flush, retire, branch, halt, snap
    ph2[0] = '{3, 1, 0, 0, 0, 0, 0};
    ph2[1] = '{2, 0, 1, 0, 0, 0, 0};
    ph2[2] = '{1, 1, 1, 0, 0, 0, 0};
    ph2[3] = '{5, 0, 0, 0, 0, 0, 0};
    ph2[4] = '{1, 0, 0, 0, 0, 0, 1};
    ph3[0] = '{2, 0, 0, 1, 1, 0, 0};
    ph3[1] = '{5, 0, 0, 1, 0, 0, 0};
    ph3[2] = '{1, 0, 0, 0, 0, 1, 0};
    ph3[3] = '{5, 1, 1, 1, 1, 0, 0};
    ph3[4] = '{1, 0, 0, 0, 0, 0, 1};
    rd[0]  = '{1, 3'd0, 32'd10};
    rd[1]  = '{1, 3'd1, 32'd0};
    rd[2]  = '{1, 3'd2, 32'd0};
    rd[3]  = '{1, 3'd3, 32'd0};
    rd[4]  = '{1, 3'd4, 32'd0};
    rd[5]  = '{1, 3'd5, 32'd0};
    rd[6]  = '{2, 3'd0, 32'd12};
    rd[7]  = '{2, 3'd1, 32'd3};
    rd[8]  = '{2, 3'd2, 32'd3};
    rd[9]  = '{2, 3'd3, 32'd0};
    rd[10] = '{2, 3'd4, 32'd0};
    rd[11] = '{3, 3'd0, 32'd8};
    rd[12] = '{3, 3'd1, 32'd0};
    rd[13] = '{3, 3'd2, 32'd0};
    rd[14] = '{3, 3'd3, 32'd7};
    rd[15] = '{3, 3'd4, 32'd2};

    // reset state
    rst_i = 1; step(); step(); rst_i = 0;
    chk("rst_state", 32'(st_m), 32'd0);
    chk("rst_ack", 32'(ack_m), 32'd0);
    chk("rst_data", data_m, 32'd0);
    chk("rst_ovf", 32'(ovf_m), 32'd0);

    // idle cycles before start are not counted, then 10 RUN cycles
    step();
    start_i = 1; step();
    chk("t1_state_run", 32'(st_m), 32'd1);
    repeat (9) step();
    snap_req_i = 1; step(); snap_req_i = 0;
    chk("t1_ack", 32'(ack_m), 32'd1);
    do_reads(1);
    chk("t1_state", 32'(st_m), 32'd1);

    // stall / flush priority over 12 RUN cycles
    clear_i = 1; step(); clear_i = 0;
    for (int i = 0; i < 5; i++) run_phase(ph2[i]);
    chk("t2_ack", 32'(ack_m), 32'd1);
    do_reads(2);

    // retire / branch, halt, then frozen in DONE
    clear_i = 1; step(); clear_i = 0;
    for (int i = 0; i < 5; i++) run_phase(ph3[i]);
    chk("t3_ack", 32'(ack_m), 32'd1);
    chk("t3_state_done", 32'(st_m), 32'd2);
    do_reads(3);

    // saturation on the 4-bit instance
    rst_i = 1; step(); rst_i = 0;
    start_i = 1; step();
    repeat (19) step();
    snap_req_i = 1; step(); snap_req_i = 0;
    halt_i = 1; start_i = 0; step(); halt_i = 0;
    sel_i = 3'd0; step();
    chk("t4_sat_data", 32'(data_s), 32'd15);
    chk("t4_sat_ovf", 32'(ovf_s), 32'd1);
    chk("t4_main_cycles", data_m, 32'd20);
    clear_i = 1; step(); clear_i = 0;
    chk("t4_clr_ovf", 32'(ovf_s), 32'd0);
    chk("t4_clr_state", 32'(st_s), 32'd0);
    snap_req_i = 1; step(); snap_req_i = 0;
    step();
    chk("t4_clr_data", 32'(data_s), 32'd0);

    // held request: one snapshot every other cycle
    snap_req_i = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t5_ack%0d", i), 32'(ack_m), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    snap_req_i = 0;

    // reset mid-run, with a request and events pending
    start_i = 1; step();
    stall_i = 1; retire_i = 1; flush_i = 1;
    repeat (3) step();
    snap_req_i = 1; step(); snap_req_i = 0;
    sel_i = 3'd0; step();
    chk("t5_pre_rst_data", data_m, 32'd4);
    chk("t5_pre_rst_ovf", 32'(ovf_m), 32'd0);
    rst_i = 1; snap_req_i = 1; step();
    chk("t5_rst_state", 32'(st_m), 32'd0);
    chk("t5_rst_ack", 32'(ack_m), 32'd0);
    chk("t5_rst_data", data_m, 32'd0);
    chk("t5_rst_ovf", 32'(ovf_m), 32'd0);
    rst_i = 0; snap_req_i = 0; stall_i = 0; retire_i = 0; flush_i = 0; start_i = 0;
    step();

`ifdef PERF_WINDOW_EN
    // periodic snapshot every 8 RUN cycles
    rst_i = 1; step(); rst_i = 0;
    sel_i = 3'd0;
    start_i = 1; step();
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("t6_ack_k%0d", k), 32'(ack_w), (k == 8 || k == 16) ? 32'd1 : 32'd0);
      if (k == 9)  chk("t6_data8", data_w, 32'd8);
      if (k == 17) chk("t6_data16", data_w, 32'd16);
    end
    start_i = 0; step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
